adsr_envelope_gen: RTL and testbench
====================================

Name: adsr_envelope_gen

Overview:
- Gate-driven ADSR envelope generator. Supersedes the fixed-output ADSR clock divider.
- Four pot words are latched under ENABLE into attack/decay/sustain/release settings.
- A five-state FSM ramps an ENV_W-bit level at per-phase programmable step rates, derived from a shared base-tick prescaler.
- Sits between pot/switch front end and the oscillator amplitude multiplier.

Parameters:
- POT_W, 10, width of each pot input word.
- ENV_W, 12, envelope level width; must be >= POT_W.
- TICK_DIV, 500, clk50Mhz cycles per base tick (500 gives 100 kHz); must be >= 2.

Ports:
- clk50Mhz  in  1  system clock, all logic on posedge.
- Reset  in  1  synchronous, active-low reset.
- GATE  in  1  note on (1) / off (0).
- ENABLE  in  1  load strobe; pot registers update every cycle it is 1.
- POT0  in  POT_W  attack rate.
- POT1  in  POT_W  decay rate.
- POT2  in  POT_W  sustain level.
- POT3  in  POT_W  release rate.
- ENV  out  ENV_W  envelope level.
- STATE  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE.
- STEP  out  1  one-cycle pulse on every ENV change caused by a rate step.
- BUSY  out  1  STATE != IDLE.

Behaviour:
- Reset (Reset==0 at posedge): STATE=IDLE, ENV=0, STEP=0, BUSY=0, prescaler=0, phase counter=0, pot registers=0, gate_q=0. Reset mid-envelope aborts immediately; no release ramp.
- Pot registers load from POT0..3 on any edge with ENABLE=1; otherwise hold. Rate changes take effect at the next counter reload.
- Sustain target SUS = pot_s << (ENV_W-POT_W). MAX = 2^ENV_W-1.
- Prescaler counts 0..TICK_DIV-1 and free-runs; tick asserts for one cycle when count==TICK_DIV-1.
- Phase counter reloads with the current phase rate R on every state entry and on every step. On tick: if 0, then step and reload; else decrement.
  - Step period is (R+1)*TICK_DIV cycles. R=0 steps every tick.
- Gate path: GATE registered into gate_q; the FSM uses gate_q only. GATE high at edge k gives gate_q=1 after k and the transition after k+1.
- FSM transitions:
  - IDLE: gate_q=1 -> ATTACK.
  - ATTACK: on step ENV+1; when ENV==MAX after the step -> DECAY. If entered with ENV==MAX -> DECAY next cycle.
  - DECAY: if ENV<=SUS -> SUSTAIN (no step). Else on step ENV-1.
  - SUSTAIN: ENV tracks SUS; on step move 1 toward SUS using the decay rate; hold when equal.
  - RELEASE: on step ENV-1; ENV==0 -> IDLE.
- gate_q=0 in ATTACK, DECAY or SUSTAIN -> RELEASE next cycle. ENV is continuous across the transition.
- gate_q=1 in RELEASE -> ATTACK from current ENV (default).
- No wrap: ENV saturates at 0 and MAX.
- Gate fall and step on the same cycle: the step applies, then the state moves to RELEASE.

Optional Feature:
- Macro: ADSR_HARD_RETRIG_EN.
- Defined: a gate_q rising edge in any non-IDLE state forces ENV=0 and enters ATTACK (hard retrigger).
- Undefined: retrigger only from RELEASE, continuing from current ENV as above.

Decomposition:
- Package adsr_pkg: STATE encoding constants (IDLE..RELEASE) and a 3-bit state typedef.
- Sub-module adsr_tick_prescaler (TICK_DIV parameter, clk50Mhz, Reset, tick out). It is reused by future LFO blocks.

Test Plan (ENV_W=4, POT_W=4, TICK_DIV=2):
- Reset pulse low during SUSTAIN with ENV=8 -> next edge ENV=0, STATE=0, BUSY=0; pots read 0.
- ENABLE=1, POT0=0, POT1=0, POT2=8, POT3=0, GATE rises -> ATTACK after 2 edges; ENV reaches 15 after 30 more cycles; DECAY down to 8 in 14 cycles; then SUSTAIN. Exactly 22 STEP pulses.
- Same, then ENABLE=0 with POT2=2 -> SUSTAIN stays at ENV=8. Pulse ENABLE -> ENV steps down to 2 at the decay rate.
- GATE falls in ATTACK at ENV=5, POT3=1 -> RELEASE; ENV decrements every 4 cycles to 0, then IDLE.
- GATE re-rises in RELEASE at ENV=6 -> ATTACK continuing from 6 (macro off); from 0 (ADSR_HARD_RETRIG_EN).
- POT0=15 -> first attack step 32 cycles after ATTACK entry.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared state encoding for the ADSR envelope generator and its helpers.
package adsr_pkg;

  typedef logic [2:0] adsr_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_tick_prescaler.sv
// Free-running base-tick prescaler: one-cycle tick every TICK_DIV clocks.
// Kept standalone so LFO blocks can share the same tick source.
module adsr_tick_prescaler #(
  parameter int TICK_DIV = 500
) (
  input  logic clk50Mhz,
  input  logic Reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk50Mhz) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adsr_envelope_gen.sv
// Gate-driven ADSR envelope generator with pot-latched rates and sustain level.
// Define ADSR_HARD_RETRIG_EN to restart the envelope from zero on any gate re-trigger.
//
// state   | meaning
// IDLE    | no note, ENV held at 0
// ATTACK  | ENV ramps up to full scale at the attack rate
// DECAY   | ENV ramps down to the sustain level at the decay rate
// SUSTAIN | ENV follows the sustain level, moving at the decay rate
// RELEASE | gate dropped, ENV ramps down to 0 at the release rate
module adsr_envelope_gen
  import adsr_pkg::*;
#(
  parameter int POT_W    = 10,
  parameter int ENV_W    = 12,
  parameter int TICK_DIV = 500
) (
  input  logic             clk50Mhz,
  input  logic             Reset,
  input  logic             GATE,
  input  logic             ENABLE,
  input  logic [POT_W-1:0] POT0,
  input  logic [POT_W-1:0] POT1,
  input  logic [POT_W-1:0] POT2,
  input  logic [POT_W-1:0] POT3,
  output logic [ENV_W-1:0] ENV,
  output logic [2:0]       STATE,
  output logic             STEP,
  output logic             BUSY
);

  localparam int               SUS_SH     = ENV_W - POT_W;
  localparam logic [ENV_W-1:0] ENV_MAX    = '1;
  localparam logic [ENV_W-1:0] ENV_MAX_M1 = ENV_MAX - 1'b1;

  adsr_state_t      state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [POT_W-1:0] pc_q, pc_d;
  logic             step_q;
  logic             gate_q;
  logic [POT_W-1:0] pot_a_q, pot_d_q, pot_s_q, pot_r_q;
  logic [ENV_W-1:0] sus_lvl;
  logic             tick;
  logic             step_evt;
  logic             rate_step;
  logic [POT_W-1:0] rate_cur, rate_new;
`ifdef ADSR_HARD_RETRIG_EN
  logic             gate_prev_q;
`endif

  adsr_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk50Mhz(clk50Mhz),
    .Reset   (Reset),
    .tick    (tick)
  );

  function automatic logic [POT_W-1:0] phase_rate(input adsr_state_t s,
                                                  input logic [POT_W-1:0] ra,
                                                  input logic [POT_W-1:0] rd,
                                                  input logic [POT_W-1:0] rr);
    phase_rate = '0;
    case (s)
      ST_ATTACK:            phase_rate = ra;
      ST_DECAY, ST_SUSTAIN: phase_rate = rd;
      ST_RELEASE:           phase_rate = rr;
      default:              phase_rate = '0;
    endcase
  endfunction

  assign sus_lvl  = ENV_W'(pot_s_q) << SUS_SH;
  assign step_evt = tick && (pc_q == '0);
  assign rate_cur = phase_rate(state_q, pot_a_q, pot_d_q, pot_r_q);
  assign rate_new = phase_rate(state_d, pot_a_q, pot_d_q, pot_r_q);

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    rate_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gate_q) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (env_q == ENV_MAX) begin
          state_d = ST_DECAY;
        end else if (step_evt) begin
          env_d     = env_q + 1'b1;
          rate_step = 1'b1;
          if (env_q == ENV_MAX_M1) state_d = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (env_q <= sus_lvl) begin
          state_d = ST_SUSTAIN;
        end else if (step_evt) begin
          env_d     = env_q - 1'b1;
          rate_step = 1'b1;
        end
      end
      ST_SUSTAIN: begin
        if (step_evt && (env_q != sus_lvl)) begin
          env_d     = (env_q < sus_lvl) ? env_q + 1'b1 : env_q - 1'b1;
          rate_step = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (step_evt && (env_q != '0)) begin
          env_d     = env_q - 1'b1;
          rate_step = 1'b1;
        end
        if (gate_q) begin
          state_d = ST_ATTACK;
        end else if (env_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
      end
    endcase

    // A pending rate step still lands on the cycle the gate drops.
    if (!gate_q && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      state_d = ST_RELEASE;
    end

`ifdef ADSR_HARD_RETRIG_EN
    if (gate_q && !gate_prev_q && (state_q != ST_IDLE)) begin
      state_d   = ST_ATTACK;
      env_d     = '0;
      rate_step = 1'b0;
    end
`endif
  end

  always_comb begin
    pc_d = pc_q;
    if (state_d != state_q) begin
      pc_d = rate_new;
    end else if (step_evt) begin
      pc_d = rate_cur;
    end else if (tick) begin
      pc_d = pc_q - 1'b1;
    end
  end

  always_ff @(posedge clk50Mhz) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      pc_q    <= '0;
      step_q  <= 1'b0;
      gate_q  <= 1'b0;
      pot_a_q <= '0;
      pot_d_q <= '0;
      pot_s_q <= '0;
      pot_r_q <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      pc_q    <= pc_d;
      step_q  <= rate_step;
      gate_q  <= GATE;
      if (ENABLE) begin
        pot_a_q <= POT0;
        pot_d_q <= POT1;
        pot_s_q <= POT2;
        pot_r_q <= POT3;
      end
    end
  end

`ifdef ADSR_HARD_RETRIG_EN
  always_ff @(posedge clk50Mhz) begin
    if (!Reset) begin
      gate_prev_q <= 1'b0;
    end else begin
      gate_prev_q <= gate_q;
    end
  end
`endif

  assign ENV   = env_q;
  assign STATE = state_q;
  assign STEP  = step_q;
  assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Self-checking bench for adsr_envelope_gen (POT_W=4, ENV_W=4, TICK_DIV=2).
module tb_adsr_envelope_gen;

  localparam int PW   = 4;
  localparam int EW   = 4;
  localparam int TD   = 2;
  localparam int MAXV = (1 << EW) - 1;
`ifdef ADSR_HARD_RETRIG_EN
  localparam int RETRIG_ENV = 0;
`else
  localparam int RETRIG_ENV = 6;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          gate = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [EW-1:0] env;
  logic [2:0]    st;
  logic          stp;
  logic          busy;

  always #5 clk = ~clk;

  adsr_envelope_gen #(
    .POT_W(PW), .ENV_W(EW), .TICK_DIV(TD)
  ) dut (
    .clk50Mhz(clk), .Reset(rst_n), .GATE(gate), .ENABLE(en),
    .POT0(p0), .POT1(p1), .POT2(p2), .POT3(p3),
    .ENV(env), .STATE(st), .STEP(stp), .BUSY(busy)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc_no  = 0;

  // reference model: phase numbers 0 idle,1 attack,2 decay,3 sustain,4 release
  int m_ph, m_env, m_cyc, m_left, m_g, m_gp, m_stp;
  int m_pot[4];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_no, act, exp);
  endtask

  function automatic int rate_for(input int ph);
    if (ph == 1) return m_pot[0];
    if (ph == 2 || ph == 3) return m_pot[1];
    if (ph == 4) return m_pot[3];
    return 0;
  endfunction

  function automatic void model_step();
    int nph, nenv, sus;
    bit tk, due;
    if (rst_n == 1'b0) begin
      m_ph = 0; m_env = 0; m_cyc = 0; m_left = 0; m_g = 0; m_gp = 0; m_stp = 0;
      for (int i = 0; i < 4; i++) m_pot[i] = 0;
      return;
    end
    tk   = (m_cyc % TD) == TD - 1;
    due  = tk && (m_left == 0);
    sus  = m_pot[2] * (1 << (EW - PW));
    nph  = m_ph;
    nenv = m_env;
    if (m_ph == 0) begin
      if (m_g != 0) nph = 1;
    end else if (m_ph == 1) begin
      if (m_env == MAXV) nph = 2;
      else if (due) begin
        nenv = m_env + 1;
        if (nenv == MAXV) nph = 2;
      end
    end else if (m_ph == 2) begin
      if (m_env <= sus) nph = 3;
      else if (due) nenv = m_env - 1;
    end else if (m_ph == 3) begin
      if (due && m_env < sus) nenv = m_env + 1;
      else if (due && m_env > sus) nenv = m_env - 1;
    end else begin
      if (due && m_env > 0) nenv = m_env - 1;
      if (m_g != 0) nph = 1;
      else if (m_env == 0) nph = 0;
    end
    if (m_g == 0 && m_ph >= 1 && m_ph <= 3) nph = 4;
    m_stp = (nenv != m_env) ? 1 : 0;
`ifdef ADSR_HARD_RETRIG_EN
    if (m_g != 0 && m_gp == 0 && m_ph != 0) begin
      nph = 1; nenv = 0; m_stp = 0;
    end
`endif
    if (nph != m_ph) m_left = rate_for(nph);
    else if (due) m_left = rate_for(m_ph);
    else if (tk) m_left = m_left - 1;
    if (en) begin
      m_pot[0] = int'(p0); m_pot[1] = int'(p1); m_pot[2] = int'(p2); m_pot[3] = int'(p3);
    end
    m_gp  = m_g;
    m_g   = int'(gate);
    m_cyc = (m_cyc + 1) % TD;
    m_ph  = nph;
    m_env = nenv;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    cyc_no++;
    #1;
    check("env", int'(env), m_env);
    check("state", int'(st), m_ph);
    check("step", int'(stp), m_stp);
    check("busy", int'(busy), (m_ph != 0) ? 1 : 0);
  endtask

  task automatic start_note(input int a, input int d, input int s, input int r);
    gate = 1'b0; en = 1'b0; rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    p0 = PW'(a); p1 = PW'(d); p2 = PW'(s); p3 = PW'(r);
    en = 1'b1; gate = 1'b1;
  endtask

  task automatic wait_for(input string nm, input int want_st, input int want_env,
                          input int budget, output int used);
    used = 0;
    while (used < budget && !(int'(st) == want_st && (want_env < 0 || int'(env) == want_env))) begin
      step_cycle();
      used++;
    end
    check(nm, (int'(st) == want_st && (want_env < 0 || int'(env) == want_env)) ? 1 : 0, 1);
  endtask

  function automatic logic [PW-1:0] rnd_rate();
    if ($urandom_range(0, 7) == 0) return PW'($urandom_range(0, 15));
    return PW'($urandom_range(0, 3));
  endfunction

  typedef struct {
    int a, d, s, r;
    int cyc;
    int steps;
    int env_fin;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int used, k, nsteps, prev_env;
    bit found;
    int rel_times[$];

    vecs[0] = '{0, 0, 8, 0, 47, 22, 8};
    vecs[1] = '{1, 0, 8, 0, 77, 22, 8};
    vecs[2] = '{0, 2, 4, 0, 99, 26, 4};
    vecs[3] = '{0, 0, 15, 0, 33, 15, 15};
    vecs[4] = '{0, 1, 0, 3, 93, 30, 0};

    rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    check("init_env", int'(env), 0);
    check("init_state", int'(st), 0);
    check("init_busy", int'(busy), 0);

    // full note-on profiles up to sustain
    for (int v = 0; v < 5; v++) begin
      start_note(vecs[v].a, vecs[v].d, vecs[v].s, vecs[v].r);
      k = 0; nsteps = 0; found = 0;
      while (k < 400 && !found) begin
        step_cycle();
        k++;
        if (stp) nsteps++;
        if (st == 3'd3) found = 1;
      end
      check("vec_cycles", found ? k : -1, vecs[v].cyc);
      check("vec_steps", nsteps, vecs[v].steps);
      check("vec_sus_env", int'(env), vecs[v].env_fin);
    end

    // reset during sustain aborts at once and clears the pots
    start_note(0, 0, 8, 0);
    wait_for("sus8", 3, 8, 200, used);
    check("sus8_cyc", used, 47);
    rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    check("rst_env", int'(env), 0);
    check("rst_state", int'(st), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(stp), 0);
    en = 1'b0;
    wait_for("zero_pots_sus", 3, 0, 300, used);
    check("zero_pots_cyc", used, 63);

    // sustain only follows POT2 after an ENABLE strobe
    start_note(0, 0, 8, 0);
    wait_for("sus8b", 3, 8, 200, used);
    en = 1'b0; p2 = 4'd2;
    repeat (20) step_cycle();
    check("hold8", int'(env), 8);
    en = 1'b1;
    step_cycle();
    en = 1'b0;
    wait_for("track2", 3, 2, 40, used);
    repeat (10) step_cycle();
    check("track2_hold", int'(env), 2);

    // gate drop in attack, release at rate 1 (4 cycles per step)
    start_note(0, 0, 8, 1);
    wait_for("atk5", 1, 5, 100, used);
    gate = 1'b0;
    rel_times.delete();
    prev_env = int'(env);
    k = 0;
    while (k < 200 && st != 3'd0) begin
      step_cycle();
      k++;
      if (stp && int'(env) < prev_env) rel_times.push_back(cyc_no);
      prev_env = int'(env);
    end
    check("rel_idle", int'(st), 0);
    check("rel_steps", rel_times.size(), 6);
    for (int i = 1; i < rel_times.size(); i++) check("rel_gap", rel_times[i] - rel_times[i-1], 4);

    // gate re-rise during release
    start_note(0, 0, 8, 1);
    wait_for("sus8c", 3, 8, 200, used);
    gate = 1'b0;
    wait_for("rel6", 4, 6, 100, used);
    gate = 1'b1;
    step_cycle();
    step_cycle();
    check("retrig_state", int'(st), 1);
    check("retrig_env", int'(env), RETRIG_ENV);

    // slowest attack rate: first step 32 cycles after attack entry
    start_note(15, 0, 8, 0);
    wait_for("atk_entry", 1, -1, 10, used);
    k = 0;
    found = 0;
    while (k < 100 && !found) begin
      step_cycle();
      k++;
      if (stp) found = 1;
    end
    check("slow_first_step", found ? k : -1, 32);

    // randomized traffic against the model
    gate = 1'b0;
    rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 99) == 0) gate = ~gate;
      en = ($urandom_range(0, 9) == 0);
      p0 = rnd_rate(); p1 = rnd_rate(); p3 = rnd_rate();
      p2 = PW'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 1999) != 0);
      step_cycle();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
